serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 143 ++++++++++++++
 tb/tb_serial_subtractor.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial signed subtractor: computes the exact (SIZE+1)-bit a - b, one bit per cycle, LSB first.
// Optional zero flag port enabled by defining SERIAL_SUBTRACTOR_ZERO_FLAG_EN.
module serial_subtractor #(
  parameter int SIZE = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic          busy,
  output logic          done,
  output logic [SIZE:0] result,
  output logic          overflow
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
  ,
  output logic          zero
`endif
);

  localparam int unsigned W  = SIZE + 1;
  localparam int unsigned CW = $clog2(SIZE + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [SIZE-1:0] sum_q, sum_d;
  logic            carry_q, carry_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    result_q, result_d;
  logic            overflow_q, overflow_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            last_c;
  logic            sum_bit_c;
  logic            carry_out_c;

  assign last_c      = (cnt_q == CW'(SIZE));
  assign sum_bit_c   = a_q[0] ^ ~b_q[0] ^ carry_q;
  assign carry_out_c = (a_q[0] & ~b_q[0]) | (a_q[0] & carry_q) | (~b_q[0] & carry_q);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_c) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values; the final RUN cycle forms the MSB without shifting
  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    sum_d      = sum_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = {a[SIZE-1], a};
          b_d     = {b[SIZE-1], b};
          carry_d = 1'b1;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = carry_out_c;
        if (!last_c) begin
          sum_d = {sum_bit_c, sum_q[SIZE-1:1]};
          cnt_d = cnt_q + CW'(1);
        end else begin
          result_d   = {sum_bit_c, sum_q};
          overflow_d = sum_bit_c ^ sum_q[SIZE-1];
        end
      end
      default: ;
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      carry_q    <= 1'b0;
      cnt_q      <= '0;
      result_q   <= '0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = overflow_q;

`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
  logic zero_q, zero_d;

  // Zero flag follows result into DONE
  always_comb begin
    zero_d = zero_q;
    if (state_q == S_RUN && last_c) zero_d = ({sum_bit_c, sum_q} == '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) zero_q <= 1'b0;
    else          zero_q <= zero_d;
  end

  assign zero = zero_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (SIZE=8): latency, signed boundaries, operand capture,
// held start, and mid-operation reset.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [8:0] result;
  logic       overflow;
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
  logic       zero;
`endif

  int pass_cnt = 0;
  int chk_cnt  = 0;

  serial_subtractor #(.SIZE(8)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .overflow (overflow)
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
    ,
    .zero     (zero)
`endif
  );

  always #5 clk = ~clk;

  // Returns #1 after the edge that samples start
  task automatic start_op(input logic [7:0] av, input logic [7:0] bv);
    @(posedge clk); #1;
    a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Counts edges from the start-sampling edge (edge 1) until done is seen; bounded
  task automatic wait_done(output int edges);
    edges = 1;
    while (done !== 1'b1 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00;
    #3;
    chk_cnt++;
    if ({busy, done, result, overflow} !== 12'h000)
      $display("FAIL reset_outputs got busy=%b done=%b result=%h ovf=%b want all 0", busy, done, result, overflow);
    else pass_cnt++;
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
    chk_cnt++;
    if (zero !== 1'b0) $display("FAIL reset_zero got %b want 0", zero);
    else pass_cnt++;
`endif
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_basic;
    int edges;
    start_op(8'h05, 8'h03);
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL basic_busy got %b want 1", busy);
    else pass_cnt++;
    wait_done(edges);
    chk_cnt++;
    if (edges !== 10) $display("FAIL basic_latency got %0d edges want 10", edges);
    else pass_cnt++;
    chk_cnt++;
    if (result !== 9'h002 || overflow !== 1'b0)
      $display("FAIL basic_result got %h ovf=%b want 002 ovf=0", result, overflow);
    else pass_cnt++;
    a = 8'hAA; b = 8'h55;
    @(posedge clk); #1;
    chk_cnt++;
    if (done !== 1'b0 || busy !== 1'b0) $display("FAIL basic_pulse got done=%b busy=%b want 0 0", done, busy);
    else pass_cnt++;
    repeat (3) begin @(posedge clk); #1; end
    chk_cnt++;
    if (result !== 9'h002 || overflow !== 1'b0)
      $display("FAIL basic_hold got %h ovf=%b want 002 ovf=0", result, overflow);
    else pass_cnt++;
  endtask

  task automatic test_boundaries;
    int edges;
    start_op(8'h80, 8'h01);
    wait_done(edges);
    chk_cnt++;
    if (edges !== 10 || result !== 9'h17F || overflow !== 1'b1)
      $display("FAIL neg_limit got edges=%0d result=%h ovf=%b want 10 17F 1", edges, result, overflow);
    else pass_cnt++;
    start_op(8'h7F, 8'hFF);
    wait_done(edges);
    chk_cnt++;
    if (edges !== 10 || result !== 9'h080 || overflow !== 1'b1)
      $display("FAIL pos_limit got edges=%0d result=%h ovf=%b want 10 080 1", edges, result, overflow);
    else pass_cnt++;
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
    chk_cnt++;
    if (zero !== 1'b0) $display("FAIL pos_limit_zero got %b want 0", zero);
    else pass_cnt++;
`endif
    start_op(8'hFF, 8'hFF);
    wait_done(edges);
    chk_cnt++;
    if (edges !== 10 || result !== 9'h000 || overflow !== 1'b0)
      $display("FAIL equal_ops got edges=%0d result=%h ovf=%b want 10 000 0", edges, result, overflow);
    else pass_cnt++;
`ifdef SERIAL_SUBTRACTOR_ZERO_FLAG_EN
    chk_cnt++;
    if (zero !== 1'b1) $display("FAIL equal_ops_zero got %b want 1", zero);
    else pass_cnt++;
`endif
  endtask

  task automatic test_ignore_during_run;
    int edges;
    int pulses;
    start_op(8'h10, 8'h20);
    repeat (3) begin @(posedge clk); #1; end
    a = 8'h55; b = 8'h11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    edges = 5;
    while (done !== 1'b1 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
    chk_cnt++;
    if (edges !== 10 || result !== 9'h1F0 || overflow !== 1'b0)
      $display("FAIL captured_ops got edges=%0d result=%h ovf=%b want 10 1F0 0", edges, result, overflow);
    else pass_cnt++;
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done === 1'b1) pulses++;
    end
    chk_cnt++;
    if (pulses !== 0 || busy !== 1'b0)
      $display("FAIL single_done got extra=%0d busy=%b want 0 0", pulses, busy);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int edges;
    @(posedge clk); #1;
    a = 8'h03; b = 8'h07; start = 1'b1;
    @(posedge clk); #1;
    wait_done(edges);
    chk_cnt++;
    if (edges !== 10 || result !== 9'h1FC || overflow !== 1'b0)
      $display("FAIL held_first got edges=%0d result=%h ovf=%b want 10 1FC 0", edges, result, overflow);
    else pass_cnt++;
    a = 8'h7F; b = 8'h80;
    @(posedge clk); #1;
    chk_cnt++;
    if (busy !== 1'b0 || done !== 1'b0) $display("FAIL held_idle got busy=%b done=%b want 0 0", busy, done);
    else pass_cnt++;
    @(posedge clk); #1;
    start = 1'b0;
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL held_restart got busy=%b want 1", busy);
    else pass_cnt++;
    wait_done(edges);
    chk_cnt++;
    if (edges !== 10 || result !== 9'h0FF || overflow !== 1'b1)
      $display("FAIL held_second got edges=%0d result=%h ovf=%b want 10 0FF 1", edges, result, overflow);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_run;
    int edges;
    int pulses;
    start_op(8'h55, 8'h11);
    repeat (3) begin @(posedge clk); #1; end
    #2 reset_n = 1'b0;
    #1;
    chk_cnt++;
    if ({busy, done, result, overflow} !== 12'h000)
      $display("FAIL midrun_reset got busy=%b done=%b result=%h ovf=%b want all 0", busy, done, result, overflow);
    else pass_cnt++;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    pulses = 0;
    repeat (14) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) pulses++;
    end
    chk_cnt++;
    if (pulses !== 0) $display("FAIL midrun_abort got %0d active cycles want 0", pulses);
    else pass_cnt++;
    start_op(8'h01, 8'h02);
    wait_done(edges);
    chk_cnt++;
    if (edges !== 10 || result !== 9'h1FF || overflow !== 1'b0)
      $display("FAIL after_reset got edges=%0d result=%h ovf=%b want 10 1FF 0", edges, result, overflow);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_ignore_during_run();
    test_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
